// File: rtl/pc_control_unit.sv
// Program-counter control: next-PC selection, redirect counter and an optional
// circular return-address stack, compiled in by defining PC_CTRL_RAS_EN.
module pc_control_unit #(
  parameter int unsigned         ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
  parameter int unsigned         RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              jump,
  input  logic              jump_reg,
  input  logic              branch,
  input  logic [1:0]        br_cond,
  input  logic              zeroFlag,
  input  logic              ltFlag,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] imm,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [ADDR_W-1:0] reg_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [1:0]        pc_sel,
  output logic [15:0]       redirect_cnt,
  output logic              ras_empty,
  output logic              ras_full
);

  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_redirect_cnt;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_next_pc;
  logic [ADDR_W-1:0] w_ret_target;
  logic [1:0]        w_pc_sel;
  logic              w_cond;
  logic              w_br_taken;
  logic              w_ret_sel;
  logic              w_ras_empty;
  logic              w_ras_full;

  assign w_pc_plus4 = r_pc + ADDR_W'(4);

  always_comb begin
    w_cond = 1'b0;
    unique case (br_cond)
      2'b00: w_cond = zeroFlag;
      2'b01: w_cond = ~zeroFlag;
      2'b10: w_cond = ltFlag;
      2'b11: w_cond = ~ltFlag;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_br_taken = branch & w_cond;
  // A ret only acts (and pops) when neither jump form outranks it.
  assign w_ret_sel  = ret & ~jump & ~jump_reg;

  always_comb begin
    w_pc_sel = 2'b00;
    w_target = w_pc_plus4;
    if (jump) begin
      w_pc_sel = 2'b10;
      w_target = jump_target;
    end else if (jump_reg) begin
      w_pc_sel = 2'b11;
      w_target = reg_target;
    end else if (ret) begin
      w_pc_sel = 2'b11;
      w_target = w_ret_target;
    end else if (w_br_taken) begin
      w_pc_sel = 2'b01;
      w_target = r_pc + imm;
    end
  end

  assign w_next_pc = {w_target[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc           <= RESET_PC;
      r_redirect_cnt <= '0;
    end else if (!stall) begin
      r_pc <= w_next_pc;
      if (w_pc_sel != 2'b00 && r_redirect_cnt != 16'hFFFF) begin
        r_redirect_cnt <= r_redirect_cnt + 16'd1;
      end
    end
  end

`ifdef PC_CTRL_RAS_EN
  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] r_stack [RAS_DEPTH];
  logic [PtrW-1:0]   r_sp;
  logic [CntW-1:0]   r_cnt;
  logic [PtrW-1:0]   w_top_idx;

  // r_sp addresses the next free slot; once full it also addresses the oldest entry.
  assign w_top_idx    = r_sp - PtrW'(1);
  assign w_ras_empty  = (r_cnt == '0);
  assign w_ras_full   = (r_cnt == CntW'(RAS_DEPTH));
  assign w_ret_target = w_ras_empty ? reg_target : r_stack[w_top_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_stack[i] <= '0;
      end
    end else if (!stall) begin
      if (call && w_ret_sel && !w_ras_empty) begin
        r_stack[w_top_idx] <= w_pc_plus4;
      end else if (call) begin
        r_stack[r_sp] <= w_pc_plus4;
        r_sp          <= r_sp + PtrW'(1);
        if (!w_ras_full) begin
          r_cnt <= r_cnt + CntW'(1);
        end
      end else if (w_ret_sel && !w_ras_empty) begin
        r_sp  <= w_top_idx;
        r_cnt <= r_cnt - CntW'(1);
      end
    end
  end
`else
  logic w_unused_call;

  assign w_unused_call = call;
  assign w_ras_empty   = 1'b1;
  assign w_ras_full    = 1'b0;
  assign w_ret_target  = reg_target;
`endif

  assign pc           = r_pc;
  assign pc_plus4     = w_pc_plus4;
  assign pc_sel       = w_pc_sel;
  assign redirect_cnt = r_redirect_cnt;
  assign ras_empty    = w_ras_empty;
  assign ras_full     = w_ras_full;

endmodule

// File: tb/tb_pc_control_unit.sv
// Bench for pc_control_unit: directed scenarios plus randomized traffic against a
// queue-based reference model; follows PC_CTRL_RAS_EN the same way as the design.
module tb_pc_control_unit;

`ifdef PC_CTRL_RAS_EN
  localparam bit RasEn = 1'b1;
`else
  localparam bit RasEn = 1'b0;
`endif
  localparam int unsigned Depth   = 4;
  localparam logic [31:0] ResetPc = 32'h100;

  logic        clk = 1'b0;
  logic        rst, stall, jump, jump_reg, branch, zeroFlag, ltFlag, call, ret;
  logic [1:0]  br_cond;
  logic [31:0] imm, jump_target, reg_target;
  logic [31:0] pc, pc_plus4;
  logic [1:0]  pc_sel;
  logic [15:0] redirect_cnt;
  logic        ras_empty, ras_full;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  int unsigned m_cnt;
  logic [31:0] m_ras[$];

  always #5 clk = ~clk;

  pc_control_unit #(
    .ADDR_W   (32),
    .RESET_PC (ResetPc),
    .RAS_DEPTH(Depth)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .jump        (jump),
    .jump_reg    (jump_reg),
    .branch      (branch),
    .br_cond     (br_cond),
    .zeroFlag    (zeroFlag),
    .ltFlag      (ltFlag),
    .call        (call),
    .ret         (ret),
    .imm         (imm),
    .jump_target (jump_target),
    .reg_target  (reg_target),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .pc_sel      (pc_sel),
    .redirect_cnt(redirect_cnt),
    .ras_empty   (ras_empty),
    .ras_full    (ras_full)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    rst = 0; stall = 0; jump = 0; jump_reg = 0; branch = 0; br_cond = 2'b00;
    zeroFlag = 0; ltFlag = 0; call = 0; ret = 0;
    imm = 0; jump_target = 0; reg_target = 0;
  endtask

  // One clock: check outputs mid-cycle against the model, advance the model, step the edge.
  task automatic run_cycle(output logic [1:0] sel_o);
    logic        taken;
    logic [1:0]  e_sel;
    logic [31:0] e_tgt;
    logic        ret_act;
    @(negedge clk);
    case (br_cond)
      2'd0: taken = zeroFlag;
      2'd1: taken = !zeroFlag;
      2'd2: taken = ltFlag;
      default: taken = !ltFlag;
    endcase
    taken = taken && branch;
    ret_act = ret && !jump && !jump_reg;
    if (jump)          begin e_sel = 2; e_tgt = jump_target; end
    else if (jump_reg) begin e_sel = 3; e_tgt = reg_target; end
    else if (ret)      begin
      e_sel = 3;
      e_tgt = (RasEn && m_ras.size() > 0) ? m_ras[$] : reg_target;
    end
    else if (taken)    begin e_sel = 1; e_tgt = m_pc + imm; end
    else               begin e_sel = 0; e_tgt = m_pc + 32'd4; end
    e_tgt = e_tgt & ~32'd3;

    check_eq("pc", pc, m_pc);
    check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
    check_eq("pc_sel", {30'd0, pc_sel}, {30'd0, e_sel});
    check_eq("redirect_cnt", {16'd0, redirect_cnt}, m_cnt);
    check_eq("ras_empty", {31'd0, ras_empty}, (!RasEn || m_ras.size() == 0) ? 32'd1 : 32'd0);
    check_eq("ras_full", {31'd0, ras_full}, (RasEn && m_ras.size() == Depth) ? 32'd1 : 32'd0);
    sel_o = pc_sel;

    if (rst) begin
      m_pc  = ResetPc;
      m_cnt = 0;
      m_ras.delete();
    end else if (!stall) begin
      if (RasEn) begin
        if (call && ret_act && m_ras.size() > 0) begin
          m_ras[m_ras.size()-1] = m_pc + 32'd4;
        end else if (call) begin
          m_ras.push_back(m_pc + 32'd4);
          if (m_ras.size() > Depth) void'(m_ras.pop_front());
        end else if (ret_act && m_ras.size() > 0) begin
          void'(m_ras.pop_back());
        end
      end
      if (e_sel != 0 && m_cnt < 65535) m_cnt++;
      m_pc = e_tgt;
    end
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  sel;
  logic [31:0] held_pc;
  logic [15:0] held_cnt;
  logic        held_empty;

  initial begin
    set_idle();
    rst = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
    m_pc = ResetPc; m_cnt = 0; m_ras.delete();
    check_eq("reset_pc", pc, 32'h100);
    check_eq("reset_cnt", {16'd0, redirect_cnt}, 32'd0);
    check_eq("reset_empty", {31'd0, ras_empty}, 32'd1);
    check_eq("reset_full", {31'd0, ras_full}, 32'd0);

    // Taken NE branch with negative offset
    branch = 1; br_cond = 2'b01; zeroFlag = 0; imm = 32'hFFFF_FFF0;
    run_cycle(sel);
    check_eq("br_taken_sel", {30'd0, sel}, 32'd1);
    check_eq("br_taken_pc", pc, 32'hF0);
    check_eq("br_taken_cnt", {16'd0, redirect_cnt}, 32'd1);

    set_idle(); rst = 1;
    run_cycle(sel);
    set_idle();
    branch = 1; br_cond = 2'b01; zeroFlag = 1; imm = 32'hFFFF_FFF0;
    run_cycle(sel);
    check_eq("br_nt_sel", {30'd0, sel}, 32'd0);
    check_eq("br_nt_pc", pc, 32'h104);

    // Jump outranks ret and a taken branch; the ret must not pop
    set_idle(); call = 1;
    run_cycle(sel);
    set_idle();
    jump = 1; jump_target = 32'h203; ret = 1; branch = 1; br_cond = 2'b00; zeroFlag = 1;
    imm = 32'h40; reg_target = 32'h300;
    run_cycle(sel);
    check_eq("jump_prio_sel", {30'd0, sel}, 32'd2);
    check_eq("jump_prio_pc", pc, 32'h200);
    check_eq("jump_prio_empty", {31'd0, ras_empty}, RasEn ? 32'd0 : 32'd1);
    set_idle(); ret = 1; reg_target = 32'h300;
    run_cycle(sel);
    check_eq("ret_after_jump", pc, RasEn ? 32'h108 : 32'h300);

    // Five calls overflow a depth-4 stack, then drain it
    set_idle(); rst = 1;
    run_cycle(sel);
    set_idle(); jump = 1; jump_target = 32'h10;
    run_cycle(sel);
    for (int i = 0; i < 5; i++) begin
      set_idle(); call = 1; jump = 1; jump_target = 32'h20 + 32'(i) * 32'h10;
      run_cycle(sel);
    end
    check_eq("ras_full_after_5", {31'd0, ras_full}, RasEn ? 32'd1 : 32'd0);
    for (int i = 0; i < 4; i++) begin
      set_idle(); ret = 1; reg_target = 32'h999;
      run_cycle(sel);
      check_eq("ras_pop", pc, RasEn ? (32'h54 - 32'(i) * 32'h10) : 32'h998);
    end
    check_eq("ras_drained", {31'd0, ras_empty}, 32'd1);
    set_idle(); ret = 1; reg_target = 32'h999;
    run_cycle(sel);
    check_eq("ras_empty_ret", pc, 32'h998);

    // Stall holds everything while pc_sel still reflects the jump
    set_idle(); call = 1;
    run_cycle(sel);
    held_pc = pc; held_cnt = redirect_cnt; held_empty = ras_empty;
    for (int i = 0; i < 3; i++) begin
      set_idle(); stall = 1; jump = 1; jump_target = 32'h400; call = 1; ret = 1;
      run_cycle(sel);
      check_eq("stall_sel", {30'd0, sel}, 32'd2);
      check_eq("stall_pc", pc, held_pc);
      check_eq("stall_cnt", {16'd0, redirect_cnt}, {16'd0, held_cnt});
      check_eq("stall_empty", {31'd0, ras_empty}, {31'd0, held_empty});
    end
    set_idle(); jump = 1; jump_target = 32'h400;
    run_cycle(sel);
    check_eq("stall_release_pc", pc, 32'h400);

    // PC wraps modulo 2^32
    set_idle(); jump = 1; jump_target = 32'hFFFF_FFFC;
    run_cycle(sel);
    set_idle();
    run_cycle(sel);
    check_eq("pc_wrap", pc, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(99) == 0);
      stall       = ($urandom_range(4) == 0);
      jump        = ($urandom_range(9) == 0);
      jump_reg    = ($urandom_range(9) == 0);
      ret         = ($urandom_range(3) == 0);
      call        = ($urandom_range(3) == 0);
      branch      = ($urandom_range(2) == 0);
      br_cond     = 2'($urandom_range(3));
      zeroFlag    = 1'($urandom_range(1));
      ltFlag      = 1'($urandom_range(1));
      imm         = 32'($signed($urandom_range(1023)) - 512);
      jump_target = $urandom;
      reg_target  = $urandom;
      run_cycle(sel);
    end

    // Drive the redirect counter into saturation
    set_idle(); jump = 1; jump_target = 32'h0;
    repeat (65540) @(posedge clk);
    #1;
    m_pc = 32'h0; m_cnt = 65535;
    check_eq("cnt_saturated", {16'd0, redirect_cnt}, 32'hFFFF);
    run_cycle(sel);
    check_eq("cnt_stays_sat", {16'd0, redirect_cnt}, 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
